// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-codes, multiply-sequencer state encoding and
// the control bundle that is arbitrated onto the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'b0011;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0111;
  localparam logic [3:0] ALU_OP_OR   = 4'b1100;
  localparam logic [3:0] ALU_OP_AND  = 4'b1101;
  localparam logic [3:0] ALU_OP_XOR  = 4'b1110;
  localparam logic [3:0] ALU_OP_PASS = 4'b1111;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_ADD_I_ENC = 3'd1;
  localparam logic [2:0] ST_ADD_C_ENC = 3'd2;
  localparam logic [2:0] ST_SH_I_ENC  = 3'd3;
  localparam logic [2:0] ST_SH_C_ENC  = 3'd4;
  localparam logic [2:0] ST_DONE_ENC  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ADD_I = ST_ADD_I_ENC,
    ST_ADD_C = ST_ADD_C_ENC,
    ST_SH_I  = ST_SH_I_ENC,
    ST_SH_C  = ST_SH_C_ENC,
    ST_DONE  = ST_DONE_ENC
  } seq_state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       right;
    logic [7:0] ai;
    logic [7:0] bi;
    logic       ci;
    logic       bcd;
    logic       rdy;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_port_mux.sv
// Selects either the core's or the sequencer's control bundle onto the ALU.
module alu_port_mux
  import alu_pkg::*;
(
  input  logic      sel_seq,
  input  alu_ctrl_t cpu_ctrl,
  input  alu_ctrl_t seq_ctrl,
  output alu_ctrl_t alu_ctrl
);

  assign alu_ctrl = sel_seq ? seq_ctrl : cpu_ctrl;

endmodule

// File: rtl/alu_mul_seq.sv
// Multiply sequencer: borrows the shared ALU to run an unsigned 8x8
// shift-and-add multiply, stalling the core while it owns the ALU.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  mul_a,
  input  logic [7:0]  mul_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] prod,
  output logic        cpu_stall,
  input  logic [3:0]  cpu_op,
  input  logic        cpu_right,
  input  logic [7:0]  cpu_ai,
  input  logic [7:0]  cpu_bi,
  input  logic        cpu_ci,
  input  logic        cpu_bcd,
  input  logic        cpu_rdy,
  output logic [3:0]  alu_op,
  output logic        alu_right,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  output logic        alu_bcd,
  output logic        alu_rdy,
  input  logic [7:0]  alu_out,
  input  logic        alu_co
);

  seq_state_t state, state_nxt;
  logic [7:0] m, p, q;
  logic       c;
  logic [2:0] cnt;
  alu_ctrl_t  cpu_ctrl, seq_ctrl, alu_ctrl;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seq_ctrl  = '{op: ALU_OP_PASS, right: 1'b0, ai: 8'h00, bi: 8'h00,
                  ci: 1'b0, bcd: 1'b0, rdy: 1'b0};
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (mul_b[0] || !SKIP_ZERO) ? ST_ADD_I : ST_SH_I;
      end
      ST_ADD_I: begin
        seq_ctrl.ai  = p;
        seq_ctrl.rdy = 1'b1;
        if (q[0]) begin
          seq_ctrl.op = ALU_OP_ADD;
          seq_ctrl.bi = m;
        end
        state_nxt = ST_ADD_C;
      end
      ST_ADD_C: state_nxt = ST_SH_I;
      ST_SH_I: begin
        seq_ctrl.right = 1'b1;
        seq_ctrl.ai    = p;
        seq_ctrl.ci    = c;
        seq_ctrl.rdy   = 1'b1;
        state_nxt      = ST_SH_C;
      end
      ST_SH_C: begin
        // q[1] becomes the new Q[0] once this shift commits
        if (cnt == 3'd7)             state_nxt = ST_DONE;
        else if (q[1] || !SKIP_ZERO) state_nxt = ST_ADD_I;
        else                         state_nxt = ST_SH_I;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m    <= 8'h00;
      p    <= 8'h00;
      q    <= 8'h00;
      c    <= 1'b0;
      cnt  <= 3'd0;
      prod <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m   <= mul_a;
            q   <= mul_b;
            p   <= 8'h00;
            c   <= 1'b0;
            cnt <= 3'd0;
          end
        end
        ST_ADD_C: begin
          p <= alu_out;
          c <= alu_co;
        end
        ST_SH_C: begin
          p   <= alu_out;
          q   <= {alu_co, q[7:1]};
          c   <= 1'b0;
          cnt <= cnt + 3'd1;
          // capture {P,Q} as it will stand in DONE so prod is valid with done
          if (cnt == 3'd7) prod <= {alu_out, alu_co, q[7:1]};
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign cpu_stall = busy;

  assign cpu_ctrl = '{op: cpu_op, right: cpu_right, ai: cpu_ai, bi: cpu_bi,
                      ci: cpu_ci, bcd: cpu_bcd, rdy: cpu_rdy};

  alu_port_mux u_mux (
    .sel_seq  (busy),
    .cpu_ctrl (cpu_ctrl),
    .seq_ctrl (seq_ctrl),
    .alu_ctrl (alu_ctrl)
  );

  assign alu_op    = alu_ctrl.op;
  assign alu_right = alu_ctrl.right;
  assign alu_ai    = alu_ctrl.ai;
  assign alu_bi    = alu_ctrl.bi;
  assign alu_ci    = alu_ctrl.ci;
  assign alu_bcd   = alu_ctrl.bcd;
  assign alu_rdy   = alu_ctrl.rdy;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench: two sequencers (SKIP_ZERO=1 and 0), each with a
// behavioural registered ALU; expected products/done cycles are queued.
module tb_alu_mul_seq;

  typedef struct {
    logic [15:0] prod;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [3:0] cpu_op    = 4'h0;
  logic       cpu_right = 1'b0;
  logic [7:0] cpu_ai    = 8'h00;
  logic [7:0] cpu_bi    = 8'h00;
  logic       cpu_ci    = 1'b0;
  logic       cpu_bcd   = 1'b0;
  logic       cpu_rdy   = 1'b0;
  wire [23:0] cpu_bundle = {cpu_op, cpu_right, cpu_ai, cpu_bi, cpu_ci, cpu_bcd, cpu_rdy};

  // ---- instance 0: SKIP_ZERO=1 ----
  logic        rst0 = 1'b1, start0 = 1'b0;
  logic [7:0]  a0 = 8'h00, b0 = 8'h00;
  logic        busy0, done0, stall0;
  logic [15:0] prod0;
  logic [3:0]  op0;
  logic        right0, ci0, bcd0, rdy0;
  logic [7:0]  ai0, bi0;
  logic [7:0]  out0 = 8'h00;
  logic        co0 = 1'b0;
  wire [23:0]  alu_bundle0 = {op0, right0, ai0, bi0, ci0, bcd0, rdy0};

  alu_mul_seq #(.SKIP_ZERO(1'b1)) dut0 (
    .clk(clk), .reset(rst0), .start(start0), .mul_a(a0), .mul_b(b0),
    .busy(busy0), .done(done0), .prod(prod0), .cpu_stall(stall0),
    .cpu_op(cpu_op), .cpu_right(cpu_right), .cpu_ai(cpu_ai), .cpu_bi(cpu_bi),
    .cpu_ci(cpu_ci), .cpu_bcd(cpu_bcd), .cpu_rdy(cpu_rdy),
    .alu_op(op0), .alu_right(right0), .alu_ai(ai0), .alu_bi(bi0),
    .alu_ci(ci0), .alu_bcd(bcd0), .alu_rdy(rdy0),
    .alu_out(out0), .alu_co(co0)
  );

  // ---- instance 1: SKIP_ZERO=0 ----
  logic        rst1 = 1'b1, start1 = 1'b0;
  logic [7:0]  a1 = 8'h00, b1 = 8'h00;
  logic        busy1, done1, stall1;
  logic [15:0] prod1;
  logic [3:0]  op1;
  logic        right1, ci1, bcd1, rdy1;
  logic [7:0]  ai1, bi1;
  logic [7:0]  out1 = 8'h00;
  logic        co1 = 1'b0;

  alu_mul_seq #(.SKIP_ZERO(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .mul_a(a1), .mul_b(b1),
    .busy(busy1), .done(done1), .prod(prod1), .cpu_stall(stall1),
    .cpu_op(cpu_op), .cpu_right(cpu_right), .cpu_ai(cpu_ai), .cpu_bi(cpu_bi),
    .cpu_ci(cpu_ci), .cpu_bcd(cpu_bcd), .cpu_rdy(cpu_rdy),
    .alu_op(op1), .alu_right(right1), .alu_ai(ai1), .alu_bi(bi1),
    .alu_ci(ci1), .alu_bcd(bcd1), .alu_rdy(rdy1),
    .alu_out(out1), .alu_co(co1)
  );

  // Behavioural ALU: registers on rdy, holds otherwise.
  always @(posedge clk) begin
    if (rdy0) begin
      if (op0 == 4'b0011 && !right0) {co0, out0} <= {1'b0, ai0} + {1'b0, bi0} + {8'h00, ci0};
      else if (op0 == 4'b1111 && right0) {co0, out0} <= {ai0[0], ci0, ai0[7:1]};
      else {co0, out0} <= {1'b0, ai0};
    end
    if (rdy1) begin
      if (op1 == 4'b0011 && !right1) {co1, out1} <= {1'b0, ai1} + {1'b0, bi1} + {8'h00, ci1};
      else if (op1 == 4'b1111 && right1) {co1, out1} <= {ai1[0], ci1, ai1[7:1]};
      else {co1, out1} <= {1'b0, ai1};
    end
  end

  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon0();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0) begin
        if (q0.size() == 0) check("dut0 unexpected done", 1, 0);
        else begin
          e = q0.pop_front();
          check("dut0 prod", {16'h0, prod0}, {16'h0, e.prod});
          check("dut0 done cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic mon1();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1) begin
        if (q1.size() == 0) check("dut1 unexpected done", 1, 0);
        else begin
          e = q1.pop_front();
          check("dut1 prod", {16'h0, prod1}, {16'h0, e.prod});
          check("dut1 done cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  // Start one multiply on dut0 and track busy/stall each cycle until done.
  task automatic run0(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] p, input int lat);
    int s;
    @(posedge clk); #1;
    a0 = a; b0 = b; start0 = 1'b1; s = cyc;
    q0.push_back('{prod: p, cyc: s + lat});
    @(posedge clk); #1;
    start0 = 1'b0;
    do begin
      @(negedge clk);
      check("dut0 busy", {31'h0, busy0}, {31'h0, (cyc - s >= 1) && (cyc - s <= lat)});
      check("dut0 cpu_stall", {31'h0, stall0}, {31'h0, busy0});
    end while (cyc - s < lat + 1);
    check("dut0 pending results", q0.size(), 0);
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] p, input int lat);
    int s;
    @(posedge clk); #1;
    a1 = a; b1 = b; start1 = 1'b1; s = cyc;
    q1.push_back('{prod: p, cyc: s + lat});
    @(posedge clk); #1;
    start1 = 1'b0;
    while (cyc - s < lat + 2) @(negedge clk);
    check("dut1 pending results", q1.size(), 0);
  endtask

  initial begin
    int s;
    fork
      mon0();
      mon1();
    join_none

    repeat (3) @(posedge clk);
    #1; rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("reset busy", {31'h0, busy0}, 0);
    check("reset done", {31'h0, done0}, 0);
    check("reset prod", {16'h0, prod0}, 0);
    check("reset cpu_stall", {31'h0, stall0}, 0);

    // pass-through while idle
    cpu_op = 4'b0011; cpu_ai = 8'h12; cpu_bi = 8'h34; cpu_rdy = 1'b1;
    cpu_right = 1'b1; cpu_ci = 1'b1; cpu_bcd = 1'b1;
    #1;
    check("pass-through bundle", {8'h0, alu_bundle0}, {8'h0, 4'b0011, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 1'b1});
    check("pass-through busy", {31'h0, busy0}, 0);

    // hostile core controls during multiplies; must be ignored
    cpu_op = 4'b0111; cpu_ai = 8'hAA; cpu_bi = 8'h55;

    run0(8'h0D, 8'h0B, 16'h008F, 23);
    run0(8'hFF, 8'hFF, 16'hFE01, 33);
    run0(8'h80, 8'h80, 16'h4000, 19);
    run0(8'h00, 8'hFF, 16'h0000, 33);
    run0(8'hFF, 8'h01, 16'h00FF, 19);
    run1(8'h55, 8'h00, 16'h0000, 33);
    run1(8'h0D, 8'h0B, 16'h008F, 33);
    run1(8'hFF, 8'hFF, 16'hFE01, 33);

    // second start while busy is ignored
    @(posedge clk); #1;
    a0 = 8'hFF; b0 = 8'hFF; start0 = 1'b1; s = cyc;
    q0.push_back('{prod: 16'hFE01, cyc: s + 33});
    @(posedge clk); #1; start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1; a0 = 8'h01; b0 = 8'h01; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    while (cyc - s < 36) @(negedge clk);
    check("ignored start pending", q0.size(), 0);
    check("ignored start idle", {31'h0, busy0}, 0);

    // reset mid-multiply
    @(posedge clk); #1;
    a0 = 8'h07; b0 = 8'h03; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst0 = 1'b1;
    @(posedge clk); #1; rst0 = 1'b0;
    check("mid reset busy", {31'h0, busy0}, 0);
    check("mid reset prod", {16'h0, prod0}, 0);
    check("mid reset pass-through", {8'h0, alu_bundle0}, {8'h0, cpu_bundle});
    repeat (30) @(posedge clk);
    #1; check("mid reset stays idle", {31'h0, busy0}, 0);

    // start and reset together: reset wins
    @(posedge clk); #1;
    a0 = 8'h03; b0 = 8'h05; start0 = 1'b1; rst0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; rst0 = 1'b0;
    check("start+reset busy", {31'h0, busy0}, 0);
    repeat (3) @(posedge clk);
    #1; check("start+reset still idle", {31'h0, busy0}, 0);
    run0(8'h03, 8'h05, 16'h000F, 21);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
